// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared FSM state type and default widths for the memory arbiter
package mem_arb_pkg;

  localparam int ADDR_W_DEF = 5;
  localparam int DATA_W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/mem_rr_pick.sv
// rtl/mem_rr_pick.sv - two-way round-robin winner selection
module mem_rr_pick (
  input  logic [1:0] req,
  input  logic       last,
  output logic       valid,
  output logic       idx
);

  assign valid = |req;

  // On a tie the requester that did not win last time goes next.
  always_comb begin
    idx = 1'b0;
    case (req)
      2'b11:   idx = ~last;
      2'b10:   idx = 1'b1;
      default: idx = 1'b0;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - two-requester round-robin arbiter for a single-port memory
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int RD_LAT = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [2*ADDR_W-1:0] addr_i,
  input  logic [2*DATA_W-1:0] wdata_i,
  output logic [1:0]          ack_o,
  output logic [DATA_W-1:0]   rdata_o,
  output logic                busy_o,
  output logic                mem_read,
  output logic                mem_write,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_data_in,
  input  logic [DATA_W-1:0]   mem_data_out
);

  localparam int CNT_W = 2;

  state_t              state, state_nxt;
  logic                pick_valid, pick_idx;
  logic                last;
  logic                lat_we, lat_idx;
  logic [ADDR_W-1:0]   lat_addr;
  logic [DATA_W-1:0]   lat_data;
  logic [CNT_W-1:0]    cnt;
  logic [DATA_W-1:0]   rdata;

  mem_rr_pick u_pick (
    .req   (req_i),
    .last  (last),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_valid) state_nxt = ACCESS;
      ACCESS:  state_nxt = lat_we ? DONE : WAIT;
      WAIT:    if (cnt == '0) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant latch, read-latency counter and read-data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      last     <= 1'b1;
      lat_we   <= 1'b0;
      lat_idx  <= 1'b0;
      lat_addr <= '0;
      lat_data <= '0;
      cnt      <= '0;
      rdata    <= '0;
    end else begin
      if (state == IDLE && pick_valid) begin
        last     <= pick_idx;
        lat_idx  <= pick_idx;
        lat_we   <= we_i[pick_idx];
        lat_addr <= pick_idx ? addr_i[ADDR_W +: ADDR_W]  : addr_i[0 +: ADDR_W];
        lat_data <= pick_idx ? wdata_i[DATA_W +: DATA_W] : wdata_i[0 +: DATA_W];
      end
      if (state == ACCESS && !lat_we)
        cnt <= CNT_W'(RD_LAT - 1);
      else if (state == WAIT && cnt != '0)
        cnt <= cnt - 1'b1;
      if (state == WAIT && cnt == '0)
        rdata <= mem_data_out;
    end
  end

  // Outputs are forced low while rst is asserted so nothing leaks out mid-reset.
  always_comb begin
    ack_o       = 2'b00;
    busy_o      = 1'b0;
    mem_read    = 1'b0;
    mem_write   = 1'b0;
    mem_addr    = '0;
    mem_data_in = '0;
    rdata_o     = '0;
    if (!rst) begin
      busy_o      = (state != IDLE);
      mem_write   = (state == ACCESS) &&  lat_we;
      mem_read    = (state == ACCESS) && !lat_we;
      mem_addr    = lat_addr;
      mem_data_in = lat_data;
      rdata_o     = rdata;
      if (state == DONE)
        ack_o = lat_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - directed, table-driven bench for mem_arbiter with a 32x8 memory model
module tb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  req_i, we_i;
  logic [9:0]  addr_i;
  logic [15:0] wdata_i;
  logic [1:0]  ack_o;
  logic [7:0]  rdata_o;
  logic        busy_o, mem_read, mem_write;
  logic [4:0]  mem_addr;
  logic [7:0]  mem_data_in;
  logic [7:0]  mem_data_out;
  logic [7:0]  mem [32];

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(5), .DATA_W(8), .RD_LAT(1)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_i        (req_i),
    .we_i         (we_i),
    .addr_i       (addr_i),
    .wdata_i      (wdata_i),
    .ack_o        (ack_o),
    .rdata_o      (rdata_o),
    .busy_o       (busy_o),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  // Memory with one cycle of read latency.
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) mem[i] <= 8'h00;
      mem_data_out <= 8'h00;
    end else begin
      if (mem_write) mem[mem_addr] <= mem_data_in;
      if (mem_read)  mem_data_out <= mem[mem_addr];
    end
  end

  typedef struct {
    logic [1:0] req;
    logic [1:0] we;
    logic [4:0] a0, a1;
    logic [7:0] d0, d1;
    logic [1:0] exp_ack;
    int         exp_lat;
    logic [7:0] exp_rd;
  } vec_t;

  vec_t vecs [10];

  logic [1:0] t_ack;
  int         t_lat;
  logic [7:0] t_rd;
  logic       t_sw, t_sr;
  logic [4:0] t_sa;
  logic [7:0] t_sd;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; req_i = 2'b00; we_i = 2'b00; addr_i = '0; wdata_i = '0;
    @(negedge clk);
    @(negedge clk);
    check("reset_outputs",
          {ack_o, busy_o, mem_read, mem_write, mem_addr, mem_data_in, rdata_o}, 32'd0);
    rst = 1'b0;
  endtask

  // Presents a request in an IDLE cycle for one cycle, then observes the strobe and the ack.
  task automatic txn(input logic [1:0] rq, input logic [1:0] w, input logic [9:0] ad,
                     input logic [15:0] wd);
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    req_i = rq; we_i = w; addr_i = ad; wdata_i = wd;
    @(negedge clk);
    req_i = 2'b00;
    t_sw = mem_write; t_sr = mem_read; t_sa = mem_addr; t_sd = mem_data_in;
    t_lat = 1;
    while (ack_o == 2'b00 && t_lat < 12) begin
      @(negedge clk);
      t_lat++;
    end
    t_ack = ack_o;
    t_rd  = rdata_o;
  endtask

  initial begin
    logic [1:0] acks [4];
    int         ack_cyc [4];
    int         n_ack;
    logic       any_ack;
    logic       w;

    vecs[0] = '{2'b01, 2'b01, 5'd5,  5'd0,  8'hA5, 8'h00, 2'b01, 2, 8'h00};
    vecs[1] = '{2'b10, 2'b00, 5'd0,  5'd5,  8'h00, 8'h00, 2'b10, 3, 8'hA5};
    vecs[2] = '{2'b11, 2'b11, 5'd3,  5'd4,  8'h33, 8'h44, 2'b01, 2, 8'hA5};
    vecs[3] = '{2'b11, 2'b11, 5'd7,  5'd8,  8'h77, 8'h88, 2'b10, 2, 8'hA5};
    vecs[4] = '{2'b01, 2'b00, 5'd3,  5'd0,  8'h00, 8'h00, 2'b01, 3, 8'h33};
    vecs[5] = '{2'b01, 2'b00, 5'd8,  5'd0,  8'h00, 8'h00, 2'b01, 3, 8'h88};
    vecs[6] = '{2'b11, 2'b00, 5'd7,  5'd3,  8'h00, 8'h00, 2'b10, 3, 8'h33};
    vecs[7] = '{2'b10, 2'b10, 5'd0,  5'd31, 8'h00, 8'hFF, 2'b10, 2, 8'h33};
    vecs[8] = '{2'b11, 2'b00, 5'd31, 5'd0,  8'h00, 8'h00, 2'b01, 3, 8'hFF};
    vecs[9] = '{2'b10, 2'b00, 5'd0,  5'd0,  8'h00, 8'h00, 2'b10, 3, 8'h00};

    rst = 1'b1; req_i = 2'b00; we_i = 2'b00; addr_i = '0; wdata_i = '0;
    do_reset();

    // Table: single transactions, req dropped in the ACCESS cycle.
    for (int i = 0; i < 10; i++) begin
      txn(vecs[i].req, vecs[i].we, {vecs[i].a1, vecs[i].a0}, {vecs[i].d1, vecs[i].d0});
      w = vecs[i].exp_ack[1];
      check($sformatf("v%0d_wr_strobe", i), t_sw, vecs[i].we[w]);
      check($sformatf("v%0d_rd_strobe", i), t_sr, !vecs[i].we[w]);
      check($sformatf("v%0d_addr", i), t_sa, w ? vecs[i].a1 : vecs[i].a0);
      check($sformatf("v%0d_wdata", i), t_sd, w ? vecs[i].d1 : vecs[i].d0);
      check($sformatf("v%0d_ack", i), t_ack, vecs[i].exp_ack);
      check($sformatf("v%0d_latency", i), t_lat, vecs[i].exp_lat);
      check($sformatf("v%0d_rdata", i), t_rd, vecs[i].exp_rd);
      @(negedge clk);
      check($sformatf("v%0d_after", i), {ack_o, mem_read, mem_write, mem_addr},
            {2'b00, 2'b00, t_sa});
    end

    // Both requesters hold req: grants alternate with a 3-cycle period.
    do_reset();
    for (int i = 0; i < 4; i++) begin acks[i] = 2'b00; ack_cyc[i] = 0; end
    n_ack = 0;
    @(negedge clk);
    req_i = 2'b11; we_i = 2'b11; addr_i = {5'd10, 5'd9}; wdata_i = {8'h10, 8'h09};
    for (int c = 0; c < 40 && n_ack < 4; c++) begin
      @(negedge clk);
      if (ack_o != 2'b00) begin
        acks[n_ack]    = ack_o;
        ack_cyc[n_ack] = c;
        n_ack++;
      end
    end
    req_i = 2'b00;
    for (int i = 0; i < 4; i++)
      check($sformatf("rr_grant%0d", i), acks[i], (i % 2 == 0) ? 2'b01 : 2'b10);
    for (int i = 1; i < 4; i++)
      check($sformatf("rr_gap%0d", i), ack_cyc[i] - ack_cyc[i-1], 3);

    // Reset during WAIT of a read by requester 0.
    do_reset();
    @(negedge clk);
    req_i = 2'b01; we_i = 2'b00; addr_i = {5'd0, 5'd5}; wdata_i = '0;
    @(negedge clk);
    req_i = 2'b00;
    check("abort_read_strobe", mem_read, 1'b1);
    @(negedge clk);
    check("abort_in_wait", {busy_o, ack_o}, 3'b100);
    rst = 1'b1;
    @(negedge clk);
    check("abort_quiet", {busy_o, mem_read, ack_o, rdata_o}, 12'd0);
    rst = 1'b0;
    any_ack = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (ack_o != 2'b00) any_ack = 1'b1;
    end
    check("abort_no_ack", any_ack, 1'b0);
    txn(2'b11, 2'b11, {5'd2, 5'd1}, {8'h22, 8'h11});
    check("abort_next_grant", t_ack, 2'b01);

    // Full memory sweep: clear, write data = address, read back.
    do_reset();
    for (int i = 0; i < 32; i++) txn(2'b01, 2'b01, {5'd0, 5'(i)}, 16'h0000);
    for (int i = 0; i < 32; i++) txn(2'b10, 2'b10, {5'(i), 5'd0}, {8'(i), 8'h00});
    for (int i = 0; i < 32; i++) begin
      txn((i % 2 == 0) ? 2'b01 : 2'b10, 2'b00, {5'(i), 5'(i)}, 16'h0000);
      check($sformatf("sweep_ack%0d", i), t_ack, (i % 2 == 0) ? 2'b01 : 2'b10);
      check($sformatf("sweep_rd%0d", i), t_rd, 8'(i));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 5, memory address width (32 locations).
REQ-002 Parameter DATA_W, default 8, memory data width.
REQ-003 Parameter RD_LAT, default 1, memory read latency in clk cycles (legal range 1..4).
REQ-004 clk  input  1  single clock; all logic on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 req_i  input  2  per-requester request; bit n belongs to requester n.
REQ-007 we_i  input  2  per-requester op: 1 = write, 0 = read.
REQ-008 addr_i  input  2*ADDR_W  per-requester address; requester n at [n*ADDR_W +: ADDR_W].
REQ-009 wdata_i  input  2*DATA_W  per-requester write data, packed as addr_i.
REQ-010 ack_o  output  2  one-cycle completion pulse per requester.
REQ-011 rdata_o  output  DATA_W  read data; valid only while the owning ack_o bit is high.
REQ-012 busy_o  output  1  high whenever the FSM is not in IDLE.
REQ-013 mem_read  output  1  memory read strobe.
REQ-014 mem_write  output  1  memory write strobe.
REQ-015 mem_addr  output  ADDR_W  memory address.
REQ-016 mem_data_in  output  DATA_W  memory write data.
REQ-017 mem_data_out  input  DATA_W  memory read data, valid RD_LAT cycles after the cycle mem_read is high.

Function
REQ-018 The FSM SHALL have states IDLE, ACCESS, WAIT and DONE.
REQ-019 IDLE, any req_i bit high: pick a winner, latch its we/addr/wdata and index, go to ACCESS.
REQ-020 IDLE, no request: stay in IDLE.
REQ-021 ACCESS lasts one cycle: mem_addr/mem_data_in from latched values; mem_write=1 for writes, mem_read=1 for reads; never both.
REQ-022 ACCESS exit: write -> DONE; read -> WAIT.
REQ-023 WAIT lasts exactly RD_LAT cycles, counted by a down-counter.
REQ-024 At the edge leaving WAIT, mem_data_out SHALL be captured into the rdata register.
REQ-025 DONE lasts one cycle: ack_o[winner]=1, then return to IDLE.
REQ-026 Latency from req sampled in IDLE at cycle k: write ack in cycle k+2, read ack in cycle k+2+RD_LAT.
REQ-027 Back-to-back: a request still high in the IDLE cycle after DONE is granted in that cycle, giving a 1-cycle gap per transaction.
REQ-028 Arbitration is round-robin: a single requester wins; with both requesting, the one not granted last wins.
REQ-029 The last-grant pointer updates only on a grant.
REQ-030 Requester inputs after the grant cycle are ignored; the latched transaction always completes and acks, even if req drops.
REQ-031 A requester keeping req high after its ack is treated as a new request.
REQ-032 Outside ACCESS: mem_read=0 and mem_write=0; mem_addr and mem_data_in hold their last values.
REQ-033 rdata_o holds its last captured value between reads.

Reset
REQ-034 When rst is sampled high, the FSM SHALL go to IDLE, the last-grant pointer to 1 (requester 0 wins the first tie), the WAIT counter to 0, rdata to 0, and the latched addr/data/index to 0.
REQ-035 During and after reset, all outputs SHALL be 0 (ack_o, busy_o, mem_read, mem_write, mem_addr, mem_data_in, rdata_o).
REQ-036 Reset mid-transaction aborts it with no ack; a pending strobe SHALL drop in the cycle after rst is sampled.

Structure
REQ-037 A shared package mem_arb_pkg SHALL hold the state enum and default ADDR_W/DATA_W constants.
REQ-038 Round-robin selection SHALL be a sub-module mem_rr_pick: inputs req[1:0], last; outputs valid, idx.

Verification
REQ-039 Reset, then requester 0 writes addr 5 data 8'hA5 -> mem_write=1 exactly in cycle k+1 with mem_addr=5 and mem_data_in=A5; ack_o=2'b01 in cycle k+2.
REQ-040 Requester 1 reads addr 5 -> mem_read in cycle k+1; ack_o=2'b10 in cycle k+3 with rdata_o=8'hA5 (RD_LAT=1).
REQ-041 Both requesters hold req continuously after reset -> grants alternate 0,1,0,1 over four transactions; no ack ever goes to both bits.
REQ-042 rst asserted during WAIT of a read -> no ack; busy_o=0 and mem_read=0 the next cycle; the next request after reset is granted to requester 0.
REQ-043 Clear all 32 locations to 0, then write data=address at each, then read back all 32 -> every rdata_o equals its address.
REQ-044 Requester 0 drops req in the ACCESS cycle -> its transaction completes and ack_o[0] still pulses.
